// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: register map, widths and timer control layout.
package mmio_pkg;

   localparam int unsigned ADR_W  = 11;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned BASE_W = 7;
   localparam int unsigned OFS_W  = 4;
   localparam int unsigned LED_W  = 10;
   localparam int unsigned SW_W   = 8;
   localparam int unsigned P_W    = 3;
   localparam int unsigned PRE_W  = 7;
   localparam int unsigned CTRL_W = P_W + 1;

   localparam logic [BASE_W-1:0] IO_BASE_DEF = 7'h7F;

   localparam logic [OFS_W-1:0] OFS_LED    = 4'd0;
   localparam logic [OFS_W-1:0] OFS_SW     = 4'd1;
   localparam logic [OFS_W-1:0] OFS_COUNT  = 4'd2;
   localparam logic [OFS_W-1:0] OFS_CMP    = 4'd3;
   localparam logic [OFS_W-1:0] OFS_STATUS = 4'd4;
   localparam logic [OFS_W-1:0] OFS_CTRL   = 4'd5;

   // CTRL register image: bits[3:1] prescale exponent, bit0 enable.
   typedef struct packed {
      logic [P_W-1:0] presc;
      logic           en;
   } ctrl_t;

   // Prescaler terminal value for one tick every 2^p clocks.
   function automatic logic [PRE_W-1:0] presc_mask(input logic [P_W-1:0] p);
      return PRE_W'((32'd1 << p) - 32'd1);
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// Timer for mmio_responder: prescaler, COUNT, CMP match and sticky STATUS flag.
module mmio_timer
   import mmio_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_i,
   input  logic [OFS_W-1:0]  ofs_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] count_o,
   output logic [DATA_W-1:0] cmp_o,
   output logic              flag_o,
   output logic [CTRL_W-1:0] ctrl_o
);

   ctrl_t             ctrl_q, ctrl_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic [DATA_W-1:0] cmp_q, cmp_d;
   logic              flag_q, flag_d;
   logic              ctrl_wr_c, tick_c;

   // A CTRL write restarts the prescaler and cancels any tick due on that edge.
   always_comb begin
      ctrl_d    = ctrl_q;
      pre_d     = pre_q;
      count_d   = count_q;
      cmp_d     = cmp_q;
      flag_d    = flag_q;
      ctrl_wr_c = wr_i && (ofs_i == OFS_CTRL);
      tick_c    = ctrl_q.en && !ctrl_wr_c && (pre_q == presc_mask(ctrl_q.presc));

      if (ctrl_wr_c) begin
         ctrl_d = ctrl_t'(wdata_i[CTRL_W-1:0]);
         pre_d  = '0;
      end else if (ctrl_q.en) begin
         pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
      end

      if (tick_c) begin
         count_d = count_q + DATA_W'(1);
      end

      if (wr_i && (ofs_i == OFS_CMP)) begin
         cmp_d = wdata_i;
      end

      // Set beats a simultaneous write-1-to-clear.
      if (tick_c && (count_d == cmp_q)) begin
         flag_d = 1'b1;
      end else if (wr_i && (ofs_i == OFS_STATUS) && wdata_i[0]) begin
         flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q  <= '0;
         pre_q   <= '0;
         count_q <= '0;
         cmp_q   <= '0;
         flag_q  <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         pre_q   <= pre_d;
         count_q <= count_d;
         cmp_q   <= cmp_d;
         flag_q  <= flag_d;
      end
   end

   assign count_o = count_q;
   assign cmp_o   = cmp_q;
   assign flag_o  = flag_q;
   assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped I/O window (LED, switches, optional timer) beside the CPU data memory.
// Define MMIO_TIMER_EN to build in the COUNT/CMP/STATUS/CTRL timer registers.
module mmio_responder
   import mmio_pkg::*;
#(
   parameter logic [BASE_W-1:0] IO_BASE     = IO_BASE_DEF,
   parameter int unsigned       SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADR_W-1:0]  adrx,
   input  logic [DATA_W-1:0] dataIn,
   input  logic              write,
   output logic [DATA_W-1:0] dataOut,
   output logic              hit,
   input  logic [SW_W-1:0]   sw,
   output logic [LED_W-1:0]  ledr,
   output logic              timerFlag
);

   localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [LED_W-1:0]             led_q, led_d;
   logic [SYNC_N-1:0][SW_W-1:0]  sync_q;
   logic [DATA_W-1:0]            rdata_q, rdata_d;
   logic                         hit_q, hit_d;
   logic                         in_win_c, wr_en_c;
   logic [OFS_W-1:0]             ofs_c;
   logic [SW_W-1:0]              sw_sync_c;

   assign in_win_c  = (adrx[ADR_W-1:OFS_W] == IO_BASE);
   assign ofs_c     = adrx[OFS_W-1:0];
   assign wr_en_c   = write && in_win_c;
   assign sw_sync_c = sync_q[SYNC_N-1];

`ifdef MMIO_TIMER_EN
   logic [DATA_W-1:0] count_c, cmp_c;
   logic              flag_c;
   logic [CTRL_W-1:0] ctrl_c;

   mmio_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (wr_en_c),
      .ofs_i   (ofs_c),
      .wdata_i (dataIn),
      .count_o (count_c),
      .cmp_o   (cmp_c),
      .flag_o  (flag_c),
      .ctrl_o  (ctrl_c)
   );

   assign timerFlag = flag_c;
`else
   logic unused_c;
   assign unused_c  = ^dataIn[DATA_W-1:LED_W];
   assign timerFlag = 1'b0;
`endif

   // Read mux samples pre-write register values, so a same-cycle write shows on the next read.
   always_comb begin
      led_d   = led_q;
      rdata_d = '0;
      hit_d   = in_win_c;

      if (wr_en_c && (ofs_c == OFS_LED)) begin
         led_d = dataIn[LED_W-1:0];
      end

      if (in_win_c) begin
         case (ofs_c)
            OFS_LED:    rdata_d = DATA_W'(led_q);
            OFS_SW:     rdata_d = DATA_W'(sw_sync_c);
`ifdef MMIO_TIMER_EN
            OFS_COUNT:  rdata_d = count_c;
            OFS_CMP:    rdata_d = cmp_c;
            OFS_STATUS: rdata_d = DATA_W'(flag_c);
            OFS_CTRL:   rdata_d = DATA_W'(ctrl_c);
`endif
            default:    rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q   <= '0;
         sync_q  <= '0;
         rdata_q <= '0;
         hit_q   <= 1'b0;
      end else begin
         led_q   <= led_d;
         sync_q  <= {sync_q[SYNC_N-2:0], sw};
         rdata_q <= rdata_d;
         hit_q   <= hit_d;
      end
   end

   assign dataOut = rdata_q;
   assign hit     = hit_q;
   assign ledr    = led_q;

endmodule
